smem_bank_ctrl: RTL
===================

# smem_bank_ctrl

Single-bank controller for the GPU shared memory: owns one 256×8 bank, arbitrates among the 16 cores' load/store requests that decode to this bank, and performs one access per transaction. Returns read data and a one-cycle `finish` pulse to the served core. Sixteen instances, one per bank, sit between the core array's `read`/`write`/`addr_in`/`data_in` buses and the per-core `finish`/`data_out` return path. Each instance's outputs are zero outside its active slot, so the top level ORs the instances together.

## Interface
- `N_CORES`, 16, number of requesters
- `ADDR_W`, 12, per-core address width; `[3:0]` is the bank select, `[11:4]` is the word index
- `DATA_W`, 8, data width
- `BANK_ID`, 0, bank number this instance serves (0–15)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `read`  in  16  per-core load request
- `write`  in  16  per-core store request
- `addr_in`  in  192  core i address at `[12i+11:12i]`
- `data_in`  in  128  core i store data at `[8i+7:8i]`
- `data_out`  out  128  load data for the served core at `[8g+7:8g]`; all other bits 0
- `finish`  out  16  one-hot, one-cycle completion pulse to the served core
- `busy`  out  1  high in ACCESS and RESPOND

## Operation
- Core i is eligible when `(read[i] | write[i])` is high, `addr_in[12i+3:12i] == BANK_ID`, and i is not the hold-off core.
- If `read[i]` and `write[i]` are both high, the request is a store.
- FSM has three states: IDLE, ACCESS, RESPOND.
  - IDLE: if any core is eligible, select grant g by round-robin starting from `ptr`. Latch g, the word index, the store data and the op, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: perform the synchronous RAM op. A store writes the latched data; a load registers `mem[word]`. Go to RESPOND. The access completes even if the core drops its request.
  - RESPOND: drive `finish[g]=1`. For a load, drive `data_out[8g+7:8g]` with the read data; for a store, that slot reads 0. Set `ptr = g+1 mod 16`, set hold-off to g, and go to IDLE.
- Hold-off: core g is ineligible only during the first IDLE cycle after RESPOND. This absorbs a registered request drop. After that cycle hold-off clears.
- Requests to other banks are ignored entirely.
- RAM contents are not reset; they are undefined until written.

## Timing
- Request sampled at edge E0 (IDLE→ACCESS). RAM op at E1 (ACCESS→RESPOND). `finish`/`data_out` are valid between E1 and E2. Return to IDLE at E2.
- Minimum period between two grants is 3 cycles; back-to-back from different cores, a new grant occurs at E2+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: `finish=0`, `data_out=0`, `busy=0`, state IDLE, `ptr=0`, hold-off none.
- Reset asserted mid-transaction aborts immediately. No `finish` is issued. A store aborted in ACCESS before E1 is not written.
- A new request arriving during ACCESS/RESPOND waits; it is evaluated in IDLE.

## Configuration
- `SMEM_RR_EN` defined: round-robin arbitration as above, with `ptr` advancing after each grant.
- `SMEM_RR_EN` undefined: fixed priority, lowest eligible index wins. `ptr` is not implemented (treated as constant 0). Hold-off still applies.

## Test plan
- Reset with `reset=0` while all requests are high → `finish=0`, `data_out=0`, `busy=0`; none change for 5 cycles.
- `BANK_ID=5`: core 3 stores 0xA7 to addr 0x125 → `finish[3]` pulses 2 cycles after the sampling edge. Core 9 then loads 0x125 → `data_out[79:72]=0xA7` with `finish[9]`, and all other `data_out` bits are 0.
- `BANK_ID=5`: core 0 loads addr 0x126 (bank 6) → no `finish`, `busy=0` for 10 cycles.
- `BANK_ID=0`: cores 2, 7, 12 hold loads to bank 0 with `ptr=0` → grants in order 2, 7, 12 every 3 cycles. Core 2 keeps its request after `finish[2]` → the next grant is 7, not 2. Under `SMEM_RR_EN`, after 12 the order wraps to 2.
- Core 4 drives `read` and `write` both high with data 0x3C to word 0x20 → a store occurs, and a later load of word 0x20 returns 0x3C.
- Assert `reset` during ACCESS of a core 1 store of 0x55 to word 0x10, then release and load word 0x10 → no `finish[1]` around the reset; the load returns the pre-reset contents, not 0x55.

Source files
------------

// File: rtl/smem_bank_ctrl.sv
// smem_bank_ctrl: one 256x8 shared-memory bank that serves one of 16 cores per 3-cycle transaction.
// Build option SMEM_RR_EN selects round-robin arbitration; without it the lowest eligible core wins.
module smem_bank_ctrl #(
    parameter int N_CORES = 16,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int BANK_ID = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        read,
    input  logic [N_CORES-1:0]        write,
    input  logic [N_CORES*ADDR_W-1:0] addr_in,
    input  logic [N_CORES*DATA_W-1:0] data_in,
    output logic [N_CORES*DATA_W-1:0] data_out,
    output logic [N_CORES-1:0]        finish,
    output logic                      busy
);
    localparam int BSEL_W = 4;
    localparam int WORD_W = ADDR_W - BSEL_W;
    localparam int DEPTH  = 1 << WORD_W;
    localparam int IDX_W  = $clog2(N_CORES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [WORD_W-1:0]  r_word;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_is_store;
    logic               r_hold_valid;
    logic [IDX_W-1:0]   r_hold_id;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [N_CORES-1:0] w_elig;
    logic               w_any;
    logic [IDX_W-1:0]   w_sel;
    logic               w_respond;
    logic [N_CORES-1:0] w_finish;

    genvar gi;

    // The just-served core is masked for one IDLE cycle so its registered request drop cannot re-grant it.
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_elig
            assign w_elig[gi] = (read[gi] | write[gi])
                && (addr_in[gi*ADDR_W +: BSEL_W] == BSEL_W'(BANK_ID))
                && !(r_hold_valid && (r_hold_id == IDX_W'(gi)));
        end
    endgenerate

`ifdef SMEM_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_pos;

    // Scan from the top of the rotation down so the entry closest to r_ptr is written last and wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_pos = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            w_pos = IDX_W'((int'(r_ptr) + k) % N_CORES);
            if (w_elig[w_pos]) begin
                w_any = 1'b1;
                w_sel = w_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (r_state == S_RESPOND) begin
            r_ptr <= IDX_W'((int'(r_grant) + 1) % N_CORES);
        end
    end
`else
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (w_elig[IDX_W'(k)]) begin
                w_any = 1'b1;
                w_sel = IDX_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_word       <= '0;
            r_wdata      <= '0;
            r_is_store   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_hold_valid <= 1'b0;
                    if (w_any) begin
                        r_grant    <= w_sel;
                        r_word     <= addr_in[int'(w_sel)*ADDR_W + BSEL_W +: WORD_W];
                        r_wdata    <= data_in[int'(w_sel)*DATA_W +: DATA_W];
                        r_is_store <= write[w_sel];
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_RESPOND;
                end
                S_RESPOND: begin
                    r_hold_valid <= 1'b1;
                    r_hold_id    <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bank RAM has no reset; an aborted ACCESS never reaches this edge because r_state is already IDLE.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS) begin
            if (r_is_store) begin
                r_mem[r_word] <= r_wdata;
            end else begin
                r_rdata <= r_mem[r_word];
            end
        end
    end

    // Outputs decode registered state only, so each instance is all-zero outside RESPOND and can be ORed.
    assign w_respond = (r_state == S_RESPOND);
    assign busy      = (r_state != S_IDLE);
    assign finish    = w_finish;

    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_out
            assign w_finish[gi] = w_respond && (r_grant == IDX_W'(gi));
            assign data_out[gi*DATA_W +: DATA_W] =
                (w_finish[gi] && !r_is_store) ? r_rdata : '0;
        end
    endgenerate

endmodule
